// File: rtl/ddr3_init_responder.sv
// DRAM-side view of the DDR3 power-up sequence: decodes the command bus at posedge ck,
// checks MR2 -> MR3 -> MR1 -> MR0 -> ZQCL ordering and spacing, latches mode registers.
module ddr3_init_responder #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 16,
  parameter int TXPR      = 108,
  parameter int TMRD      = 4,
  parameter int TMOD      = 12,
  parameter int TZQINIT   = 512,
  parameter int CNT_W     = 16
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic                 RESET,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 we_n,
  input  logic [BA_BITS-1:0]   ba,
  input  logic [ADDR_BITS-1:0] a,
  input  logic                 odt,
  output logic [ADDR_BITS-1:0] mr0,
  output logic [ADDR_BITS-1:0] mr1,
  output logic [ADDR_BITS-1:0] mr2,
  output logic [ADDR_BITS-1:0] mr3,
  output logic                 init_done,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_RST = 3'd0, S_CKE = 3'd1, S_XPR = 3'd2, S_MR3 = 3'd3,
    S_MR1 = 3'd4, S_MR0 = 3'd5, S_ZQ  = 3'd6, S_ZQW = 3'd7
  } state_t;

  // Counter value on the sampling edge is one less than the edge distance,
  // so each minimum spacing T is met when the counter has reached T-1.
  localparam logic [CNT_W-1:0] LIM_XPR = CNT_W'(TXPR - 1);
  localparam logic [CNT_W-1:0] LIM_MRD = CNT_W'(TMRD - 1);
  localparam logic [CNT_W-1:0] LIM_MOD = CNT_W'(TMOD - 1);
  localparam logic [CNT_W-1:0] LIM_ZQ  = CNT_W'(TZQINIT - 1);

  state_t                 state_q, state_d, nxt;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   mr0_q, mr0_d, mr1_q, mr1_d, mr2_q, mr2_d, mr3_q, mr3_d;
  logic                   init_done_q, init_done_d, err_q, err_d;
  logic [2:0]             code_q, code_d, t_code, sel_code;
  logic                   is_sel, is_mrs, is_zq, is_other;
  logic                   f_cke, f_order, f_zqcs, f_time, f_other, set_done;
  logic [3:0]             wr_mr;
  logic [BA_BITS-1:0]     exp_ba;
  logic [CNT_W-1:0]       lim;
  logic                   odt_unused;

  assign odt_unused = odt;

  // Anything other than a solid 0 on cs_n (including x/z) is a deselect.
  assign is_sel   = (cs_n === 1'b0);
  assign is_mrs   = is_sel && ({ras_n, cas_n, we_n} == 3'b000);
  assign is_zq    = is_sel && ({ras_n, cas_n, we_n} == 3'b110);
  assign is_other = is_sel && ({ras_n, cas_n, we_n} != 3'b111) && !is_mrs && !is_zq;

  always_comb begin
    nxt      = state_q;
    f_order  = 1'b0;
    f_zqcs   = 1'b0;
    f_time   = 1'b0;
    f_other  = 1'b0;
    t_code   = 3'd0;
    set_done = 1'b0;
    wr_mr    = 4'b0000;
    exp_ba   = BA_BITS'(2);
    lim      = LIM_MRD;
    case (state_q)
      S_XPR: begin exp_ba = BA_BITS'(2); lim = LIM_XPR; end
      S_MR3: exp_ba = BA_BITS'(3);
      S_MR1: exp_ba = BA_BITS'(1);
      S_MR0: exp_ba = BA_BITS'(0);
      default: ;
    endcase
    case (state_q)
      S_RST: nxt = S_CKE;
      S_CKE: begin
        if (is_mrs || is_zq || is_other) f_other = 1'b1;
        else if (cke) nxt = S_XPR;
      end
      S_XPR, S_MR3, S_MR1, S_MR0: begin
        if (is_zq) f_order = 1'b1;
        else if (is_mrs) begin
          if (ba != exp_ba) f_order = 1'b1;
          else if (cnt_q < lim) begin
            f_time = 1'b1;
            t_code = (state_q == S_XPR) ? 3'd2 : 3'd3;
          end else begin
            case (state_q)
              S_XPR:   begin nxt = S_MR3; wr_mr[2] = 1'b1; end
              S_MR3:   begin nxt = S_MR1; wr_mr[3] = 1'b1; end
              S_MR1:   begin nxt = S_MR0; wr_mr[1] = 1'b1; end
              default: begin nxt = S_ZQ;  wr_mr[0] = 1'b1; end
            endcase
          end
        end
      end
      S_ZQ: begin
        if (is_mrs) f_order = 1'b1;
        else if (is_zq) begin
          if (!a[10]) f_zqcs = 1'b1;
          else if (cnt_q < LIM_MOD) begin f_time = 1'b1; t_code = 3'd4; end
          else nxt = S_ZQW;
        end
      end
      default: begin
        // Once ready, normal traffic is allowed and no longer policed.
        if (!init_done_q) begin
          if (is_mrs || is_zq || is_other) begin f_time = 1'b1; t_code = 3'd4; end
          else if (cnt_q == LIM_ZQ) set_done = 1'b1;
        end
      end
    endcase
    if (!init_done_q && is_other) f_other = 1'b1;
  end

  assign f_cke = (state_q != S_RST) && (state_q != S_CKE) && !init_done_q && !cke;

  always_comb begin
    sel_code = 3'd5;
    if (f_cke)        sel_code = 3'd7;
    else if (f_order) sel_code = 3'd1;
    else if (f_zqcs)  sel_code = 3'd6;
    else if (f_time)  sel_code = t_code;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    mr0_d       = mr0_q;
    mr1_d       = mr1_q;
    mr2_d       = mr2_q;
    mr3_d       = mr3_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    code_d      = code_q;
    if (!RESET) begin
      state_d     = S_RST;
      mr0_d       = '0;
      mr1_d       = '0;
      mr2_d       = '0;
      mr3_d       = '0;
      init_done_d = 1'b0;
    end else if (err_q) begin
      cnt_d = cnt_q;
    end else if (f_cke || f_order || f_zqcs || f_time || f_other) begin
      err_d  = 1'b1;
      code_d = sel_code;
      cnt_d  = cnt_q;
    end else begin
      state_d = nxt;
      if (wr_mr[0]) mr0_d = a;
      if (wr_mr[1]) mr1_d = a;
      if (wr_mr[2]) mr2_d = a;
      if (wr_mr[3]) mr3_d = a;
      if (set_done) init_done_d = 1'b1;
    end
    // Every accepted MRS/ZQCL is also a state change, so this covers both clears.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RST;
      cnt_q       <= '0;
      mr0_q       <= '0;
      mr1_q       <= '0;
      mr2_q       <= '0;
      mr3_q       <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mr0_q       <= mr0_d;
      mr1_q       <= mr1_d;
      mr2_q       <= mr2_d;
      mr3_q       <= mr3_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign mr0       = mr0_q;
  assign mr1       = mr1_q;
  assign mr2       = mr2_q;
  assign mr3       = mr3_q;
  assign init_done = init_done_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ddr3_init_responder.sv
// Bench for ddr3_init_responder: table of init sequences plus hand-written reset/cke corner cases.
module tb_ddr3_init_responder;

  logic        ck, rst_n, RESET, cke, cs_n, ras_n, cas_n, we_n, odt;
  logic [2:0]  ba;
  logic [15:0] a;
  logic [15:0] mr0, mr1, mr2, mr3;
  logic        init_done, err;
  logic [2:0]  err_code, state_o;

  int n_vec = 0;
  int n_mis = 0;

  ddr3_init_responder dut (
    .ck(ck), .rst_n(rst_n), .RESET(RESET), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .ba(ba), .a(a), .odt(odt), .mr0(mr0), .mr1(mr1),
    .mr2(mr2), .mr3(mr3), .init_done(init_done), .err(err), .err_code(err_code),
    .state_o(state_o)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    string       nm;
    int          gap[5];
    logic [2:0]  bav[4];
    logic [15:0] av[5];
    int          act;
    int          err_at;
    logic [2:0]  code;
    logic [15:0] m0, m1, m2, m3;
    bit          done;
  } vec_t;

  typedef struct {
    string      nm;
    logic [2:0] st;
    logic       e;
  } sb_t;

  vec_t vt[10];
  sb_t  sbq[$];

  function automatic vec_t mk(string nm, int g0, int g1, int g2, int g3, int g4,
                              int b0, int b1, int b2, int b3,
                              logic [15:0] a0, logic [15:0] a1, logic [15:0] a2,
                              logic [15:0] a3, logic [15:0] a4, int act, int ea, int code,
                              logic [15:0] m0, logic [15:0] m1, logic [15:0] m2,
                              logic [15:0] m3, bit done);
    vec_t v;
    v.nm = nm;
    v.gap[0] = g0; v.gap[1] = g1; v.gap[2] = g2; v.gap[3] = g3; v.gap[4] = g4;
    v.bav[0] = 3'(b0); v.bav[1] = 3'(b1); v.bav[2] = 3'(b2); v.bav[3] = 3'(b3);
    v.av[0] = a0; v.av[1] = a1; v.av[2] = a2; v.av[3] = a3; v.av[4] = a4;
    v.act = act; v.err_at = ea; v.code = 3'(code);
    v.m0 = m0; v.m1 = m1; v.m2 = m2; v.m3 = m3; v.done = done;
    return v;
  endfunction

  // State after command j of a sequence whose first bad command is err_at.
  function automatic logic [2:0] exp_state(int j, int ea);
    if (j < ea) return (j >= 4) ? 3'd7 : 3'(3 + j);
    return (ea >= 5) ? 3'd7 : 3'(2 + ea);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [2:0] b, input logic [15:0] ad,
                       input logic csn);
    @(negedge ck);
    cs_n = csn;
    {ras_n, cas_n, we_n} = c;
    ba = b;
    a  = ad;
  endtask

  task automatic idle();
    drive(3'b111, 3'd0, 16'h0, 1'b0);
  endtask

  task automatic cmd_step(input logic [2:0] c, input logic [2:0] b, input logic [15:0] ad,
                          input logic rst_pin, input logic [2:0] est, input logic ee,
                          input string nm);
    sb_t s;
    drive(c, b, ad, 1'b0);
    RESET = rst_pin;
    sbq.push_back('{nm, est, ee});
    @(posedge ck);
    #1;
    s = sbq.pop_front();
    chk({s.nm, "_state"}, 32'(state_o), 32'(s.st));
    chk({s.nm, "_err"}, 32'(err), 32'(s.e));
  endtask

  task automatic prologue(input bit do_rst);
    cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111; cke = 1'b0; RESET = 1'b0;
    ba = 3'd0; a = 16'h0; odt = 1'b0;
    if (do_rst) begin
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
    end
    repeat (3) drive(3'b111, 3'd0, 16'h0, 1'b1);
    @(negedge ck);
    RESET = 1'b1;
    repeat (4) drive(3'b111, 3'd0, 16'h0, 1'b1);
    @(posedge ck);
    #1;
    chk("cke_wait_state", 32'(state_o), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input bit do_rst);
    int k;
    prologue(do_rst);
    @(negedge ck);
    cke = 1'b1;
    for (int j = 0; j < 5; j++) begin
      repeat (v.gap[j] - 1) idle();
      cmd_step((j < 4) ? 3'b000 : 3'b110, (j < 4) ? v.bav[j] : 3'd0, v.av[j], 1'b1,
               exp_state(j, v.err_at), (j >= v.err_at), $sformatf("%s_c%0d", v.nm, j));
    end
    if (v.act > 0) begin
      repeat (v.act - 1) idle();
      cmd_step(3'b011, 3'd0, 16'h0, 1'b1, exp_state(5, v.err_at), (5 >= v.err_at),
               {v.nm, "_act"});
    end
    if (v.done) begin
      k = 0;
      while (!init_done && k < 600) begin
        idle();
        @(posedge ck);
        #1;
        k++;
      end
      chk({v.nm, "_done_latency"}, 32'(k), 32'd512);
    end else begin
      repeat (600) idle();
      @(posedge ck);
      #1;
    end
    chk({v.nm, "_init_done"}, 32'(init_done), 32'(v.done));
    chk({v.nm, "_err_final"}, 32'(err), 32'(v.err_at < 9));
    chk({v.nm, "_err_code"}, 32'(err_code), 32'(v.code));
    chk({v.nm, "_mr0"}, 32'(mr0), 32'(v.m0));
    chk({v.nm, "_mr1"}, 32'(mr1), 32'(v.m1));
    chk({v.nm, "_mr2"}, 32'(mr2), 32'(v.m2));
    chk({v.nm, "_mr3"}, 32'(mr3), 32'(v.m3));
    chk({v.nm, "_state_final"}, 32'(state_o), 32'(exp_state(9, v.err_at)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vt[0] = mk("nominal", 108, 4, 4, 4, 12, 2, 3, 1, 0, 16'h0000, 16'h0000, 16'h0044,
               16'h0522, 16'h0400, 0, 9, 0, 16'h0522, 16'h0044, 16'h0000, 16'h0000, 1);
    vt[1] = mk("mr3_short", 108, 3, 4, 4, 12, 2, 3, 1, 0, 16'h0008, 16'h0010, 16'h0044,
               16'h0522, 16'h0400, 0, 1, 3, 16'h0000, 16'h0000, 16'h0008, 16'h0000, 0);
    vt[2] = mk("order_swap", 108, 4, 4, 4, 12, 2, 1, 3, 0, 16'h0008, 16'h0010, 16'h0044,
               16'h0522, 16'h0400, 0, 1, 1, 16'h0000, 16'h0000, 16'h0008, 16'h0000, 0);
    vt[3] = mk("zqcs", 108, 4, 4, 4, 12, 2, 3, 1, 0, 16'h0008, 16'h0010, 16'h0044,
               16'h0522, 16'h0000, 0, 4, 6, 16'h0522, 16'h0044, 16'h0008, 16'h0010, 0);
    vt[4] = mk("act_in_zqw", 108, 4, 4, 4, 12, 2, 3, 1, 0, 16'h0008, 16'h0010, 16'h0044,
               16'h0522, 16'h0400, 100, 5, 4, 16'h0522, 16'h0044, 16'h0008, 16'h0010, 0);
    vt[5] = mk("xpr_short", 107, 4, 4, 4, 12, 2, 3, 1, 0, 16'h0008, 16'h0010, 16'h0044,
               16'h0522, 16'h0400, 0, 0, 2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    vt[6] = mk("mod_short", 108, 4, 4, 4, 11, 2, 3, 1, 0, 16'h0008, 16'h0010, 16'h0044,
               16'h0522, 16'h0400, 0, 4, 4, 16'h0522, 16'h0044, 16'h0008, 16'h0010, 0);
    vt[7] = mk("long_gaps", 200, 10, 5, 7, 30, 2, 3, 1, 0, 16'h0208, 16'h0004, 16'h0006,
               16'h1d70, 16'h0400, 0, 9, 0, 16'h1d70, 16'h0006, 16'h0208, 16'h0004, 1);
    vt[8] = mk("mr0_short", 108, 4, 4, 3, 12, 2, 3, 1, 0, 16'h0008, 16'h0010, 16'h0044,
               16'h0522, 16'h0400, 0, 3, 3, 16'h0000, 16'h0044, 16'h0008, 16'h0010, 0);
    vt[9] = mk("mr1_bad_ba", 108, 4, 4, 4, 12, 2, 3, 0, 0, 16'h0008, 16'h0010, 16'h0044,
               16'h0522, 16'h0400, 0, 2, 1, 16'h0000, 16'h0000, 16'h0008, 16'h0010, 0);

    rst_n = 1'b0;
    cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111; cke = 1'b0; RESET = 1'b0;
    ba = 3'd0; a = 16'h0; odt = 1'b0;
    #3;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_mrs", 32'({mr0, mr1}) | 32'({mr2, mr3}), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vt[i], 1'b1);

    // cke falls after MR3: code 7, FSM frozen in S_MR1.
    prologue(1'b1);
    @(negedge ck);
    cke = 1'b1;
    repeat (107) idle();
    cmd_step(3'b000, 3'd2, 16'h0008, 1'b1, 3'd3, 1'b0, "ckedrop_mr2");
    repeat (3) idle();
    cmd_step(3'b000, 3'd3, 16'h0010, 1'b1, 3'd4, 1'b0, "ckedrop_mr3");
    idle();
    cke = 1'b0;
    @(posedge ck);
    #1;
    chk("ckedrop_err", 32'(err), 32'd1);
    chk("ckedrop_code", 32'(err_code), 32'd7);
    chk("ckedrop_state", 32'(state_o), 32'd4);
    // RESET pin low keeps the sticky error but clears state and mode registers.
    @(negedge ck);
    RESET = 1'b0;
    @(posedge ck);
    #1;
    chk("errhold_state", 32'(state_o), 32'd0);
    chk("errhold_err", 32'(err), 32'd1);
    chk("errhold_code", 32'(err_code), 32'd7);
    chk("errhold_mr2", 32'(mr2), 32'd0);
    chk("errhold_mr3", 32'(mr3), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_err", 32'(err), 32'd0);
    chk("async_code", 32'(err_code), 32'd0);

    // OTHER command while waiting for cke.
    prologue(1'b1);
    cmd_step(3'b011, 3'd0, 16'h0, 1'b1, 3'd1, 1'b1, "cke_act");
    chk("cke_act_code", 32'(err_code), 32'd5);

    // RESET low together with an MRS after MR3, then a complete rerun.
    prologue(1'b1);
    @(negedge ck);
    cke = 1'b1;
    repeat (107) idle();
    cmd_step(3'b000, 3'd2, 16'h0208, 1'b1, 3'd3, 1'b0, "midrst_mr2");
    repeat (3) idle();
    cmd_step(3'b000, 3'd3, 16'h0004, 1'b1, 3'd4, 1'b0, "midrst_mr3");
    chk("midrst_mr3_val", 32'(mr3), 32'h0004);
    repeat (3) idle();
    cmd_step(3'b000, 3'd1, 16'h0006, 1'b0, 3'd0, 1'b0, "midrst_reset");
    chk("midrst_mr1", 32'(mr1), 32'd0);
    chk("midrst_mr2", 32'(mr2), 32'd0);
    chk("midrst_mr3", 32'(mr3), 32'd0);
    run_vec(vt[0], 1'b0);

    // Asynchronous reset from the ready state, mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_done", 32'(init_done), 32'd0);
    chk("async_state", 32'(state_o), 32'd0);
    chk("async_mr", 32'({mr0, mr1}), 32'd0);
    #4;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
